// File: rtl/contador_2b_pkg.sv
// Shared constants for the 2-bit up/down counter.
// Holds the counter width and its maximum (wrap) value.
package contador_2b_pkg;

  localparam int CNT_W = 2;

  localparam logic [CNT_W-1:0] CNT_MAX = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE = 2'd1;

endpackage

// File: rtl/contador_2b_sync_2ff.sv
// Two-flop synchronizer for one asynchronous control bit.
// Ports: clk, rst (sync, active-high), d (async in), q (synced out).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/contador_2b.sv
// 2-bit up/down counter with synchronized enables and wrap pulse.
// Ports: clk, rst, up, down in; numero (count), desborde (wrap) out.
module contador_2b
  import contador_2b_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             up,
  input  logic             down,
  output logic [CNT_W-1:0] numero,
  output logic             desborde
);

  logic up_s;
  logic down_s;
  logic inc;
  logic dec;

  sync_2ff u_sync_up (
    .clk (clk),
    .rst (rst),
    .d   (up),
    .q   (up_s)
  );

  sync_2ff u_sync_down (
    .clk (clk),
    .rst (rst),
    .d   (down),
    .q   (down_s)
  );

  // Both enables together cancel out into a hold.
  assign inc = up_s & ~down_s;
  assign dec = down_s & ~up_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      numero   <= '0;
      desborde <= 1'b0;
    end else begin
      unique case (1'b1)
        inc: begin
          numero   <= numero + CNT_ONE;
          desborde <= (numero == CNT_MAX);
        end
        dec: begin
          numero   <= numero - CNT_ONE;
          desborde <= (numero == '0);
        end
        default: begin
          desborde <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_contador_2b.sv
// Self-checking bench for contador_2b.
// Directed steps; expected values queued per edge, popped on compare.
module tb_contador_2b;

  logic       clk;
  logic       rst;
  logic       up;
  logic       down;
  logic [1:0] numero;
  logic       desborde;

  typedef struct {
    logic [1:0] n;
    logic       w;
  } exp_t;

  exp_t exp_q[$];

  int passed = 0;
  int total  = 0;
  int pulses = 0;

  // Reference state: input pipeline plus counter.
  logic       m_u1, m_u2, m_d1, m_d2;
  logic [1:0] m_n;
  logic       m_w;

  contador_2b dut (
    .clk      (clk),
    .rst      (rst),
    .up       (up),
    .down     (down),
    .numero   (numero),
    .desborde (desborde)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic u, d, r);
    if (r) begin
      m_u1 = 0; m_u2 = 0;
      m_d1 = 0; m_d2 = 0;
      m_n  = 0; m_w  = 0;
    end else begin
      m_w = 0;
      if (m_u2 && !m_d2) begin
        m_w = (m_n == 2'd3);
        m_n = m_n + 2'd1;
      end else if (m_d2 && !m_u2) begin
        m_w = (m_n == 2'd0);
        m_n = m_n - 2'd1;
      end
      m_u2 = m_u1; m_u1 = u;
      m_d2 = m_d1; m_d1 = d;
    end
  endtask

  // Drive at negedge, model at posedge, compare at next negedge.
  task automatic step(input logic u, d, r);
    exp_t e;
    up = u; down = d; rst = r;
    @(posedge clk);
    model_edge(u, d, r);
    e.n = m_n;
    e.w = m_w;
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("numero", {6'd0, numero}, {6'd0, e.n});
    chk("desborde", {7'd0, desborde}, {7'd0, e.w});
    if (desborde === 1'b1) pulses++;
  endtask

  initial begin
    m_u1 = 0; m_u2 = 0; m_d1 = 0; m_d2 = 0;
    m_n = 0; m_w = 0;
    rst = 1'b1; up = 1'bx; down = 1'b0;
    @(negedge clk);

    // Reset release, idle inputs.
    step(1'bx, 1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    chk("rst_idle_n", {6'd0, numero}, 8'd0);

    // Continuous count of 5.
    pulses = 0;
    repeat (5) step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    chk("cont_n", {6'd0, numero}, 8'd1);
    chk("cont_pulses", pulses[7:0], 8'd1);

    // Mid-count reset with up held.
    step(1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("midrst_n", {6'd0, numero}, 8'd0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("midrst_flush", {6'd0, numero}, 8'd0);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    chk("resume_n", {6'd0, numero}, 8'd3);

    // Toggling input, 12 cycles.
    step(1'b0, 1'b0, 1'b1);
    pulses = 0;
    for (int i = 0; i < 12; i++)
      step(~i[0], 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    chk("toggle_n", {6'd0, numero}, 8'd2);
    chk("toggle_pulses", pulses[7:0], 8'd1);

    // Down wrap then simultaneous hold.
    step(1'b0, 1'b0, 1'b1);
    pulses = 0;
    step(1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    chk("down_n", {6'd0, numero}, 8'd3);
    chk("down_pulses", pulses[7:0], 8'd1);
    pulses = 0;
    repeat (3) step(1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    chk("both_n", {6'd0, numero}, 8'd3);
    chk("both_pulses", pulses[7:0], 8'd0);

    // X on inputs while in reset.
    step(1'bx, 1'bx, 1'b1);
    step(1'bx, 1'bx, 1'b1);
    chk("x_rst_n", {6'd0, numero}, 8'd0);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    chk("x_rel_n", {6'd0, numero}, 8'd0);
    chk("x_rel_w", {7'd0, desborde}, 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
